// File: rtl/rf_access_ctrl.sv
// ---------------------------------------------------------------------------
// rf_access_ctrl
// Arbitrates the register-file write port and read port 2 between the CPU
// core and the debug path. Sequences debug single write, full register dump
// over a valid/ready stream, and hardware clear of x1..x31. The core is
// stalled (cpu_halt) while any debug operation owns the RF.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   cpu_we/cpu_wr/cpu_wd       core writeback (passed through in IDLE)
//   cpu_rr2                    core read-port-2 index (passed through)
//   cpu_halt                   core stall, decoded from registered state
//   rf_we/rf_wr/rf_wd/rf_rr2   to register file
//   rf_rd2                     from register file, combinational
//   dbg_wr_*                   debug single-write request/ack
//   dump_*                     register dump stream and done pulse
//   clr_start/clr_done         clear request and done pulse
//
// Optional feature macro: RFCTL_DUMP_SKIP_X0_EN
//   defined   : dump covers x1..x31 (31 beats)
//   undefined : dump covers x0..x31 (32 beats)
// ---------------------------------------------------------------------------
module rf_access_ctrl #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_wr,
  input  logic [DW-1:0] cpu_wd,
  input  logic [AW-1:0] cpu_rr2,
  output logic          cpu_halt,
  output logic          rf_we,
  output logic [AW-1:0] rf_wr,
  output logic [DW-1:0] rf_wd,
  output logic [AW-1:0] rf_rr2,
  input  logic [DW-1:0] rf_rd2,
  input  logic          dbg_wr_req,
  input  logic [AW-1:0] dbg_wr_addr,
  input  logic [DW-1:0] dbg_wr_data,
  output logic          dbg_wr_ack,
  input  logic          dump_start,
  output logic          dump_valid,
  input  logic          dump_ready,
  output logic [AW-1:0] dump_idx,
  output logic [DW-1:0] dump_data,
  output logic          dump_done,
  input  logic          clr_start,
  output logic          clr_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DBGW  = 2'd1,
    S_DUMP  = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);
`ifdef RFCTL_DUMP_SKIP_X0_EN
  localparam logic [AW-1:0] DUMP_FIRST = AW'(1);
`else
  localparam logic [AW-1:0] DUMP_FIRST = AW'(0);
`endif

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] w_idx_nxt;
  logic          r_dump_done;
  logic          w_dump_done_nxt;
  logic          r_clr_done;
  logic          w_clr_done_nxt;

  // State, index counter and registered done pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= {AW{1'b0}};
      r_dump_done <= 1'b0;
      r_clr_done  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_dump_done <= w_dump_done_nxt;
      r_clr_done  <= w_clr_done_nxt;
    end
  end

  // Next-state logic; terminal index is checked before incrementing so the
  // counter never wraps.
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_dump_done_nxt = 1'b0;
    w_clr_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (clr_start) begin
          w_state_nxt = S_CLEAR;
          w_idx_nxt   = AW'(1);
        end else if (dump_start) begin
          w_state_nxt = S_DUMP;
          w_idx_nxt   = DUMP_FIRST;
        end else if (dbg_wr_req) begin
          w_state_nxt = S_DBGW;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DBGW: begin
        w_state_nxt = S_IDLE;
      end
      S_DUMP: begin
        if (dump_ready) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt     = S_IDLE;
            w_idx_nxt       = {AW{1'b0}};
            w_dump_done_nxt = 1'b1;
          end else begin
            w_idx_nxt = r_idx + AW'(1);
          end
        end else begin
          w_idx_nxt = r_idx;
        end
      end
      S_CLEAR: begin
        if (r_idx == LAST_IDX) begin
          w_state_nxt    = S_IDLE;
          w_idx_nxt      = {AW{1'b0}};
          w_clr_done_nxt = 1'b1;
        end else begin
          w_idx_nxt = r_idx + AW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = {AW{1'b0}};
      end
    endcase
  end

  // RF port muxing and per-state outputs. In IDLE the core owns the RF,
  // including in the cycle a request is accepted.
  always_comb begin
    rf_we      = cpu_we;
    rf_wr      = cpu_wr;
    rf_wd      = cpu_wd;
    rf_rr2     = cpu_rr2;
    dbg_wr_ack = 1'b0;
    dump_valid = 1'b0;
    dump_idx   = {AW{1'b0}};
    dump_data  = {DW{1'b0}};
    case (r_state)
      S_IDLE: begin
        rf_we = cpu_we;
      end
      S_DBGW: begin
        // A write to x0 is acknowledged but never reaches the RF.
        rf_we      = (dbg_wr_addr != {AW{1'b0}});
        rf_wr      = dbg_wr_addr;
        rf_wd      = dbg_wr_data;
        dbg_wr_ack = 1'b1;
      end
      S_DUMP: begin
        // RF is frozen while halted, so dump_data holds under back-pressure.
        rf_we      = 1'b0;
        rf_rr2     = r_idx;
        dump_valid = 1'b1;
        dump_idx   = r_idx;
        dump_data  = rf_rd2;
      end
      S_CLEAR: begin
        rf_we = 1'b1;
        rf_wr = r_idx;
        rf_wd = {DW{1'b0}};
      end
      default: begin
        rf_we = 1'b0;
      end
    endcase
  end

  assign cpu_halt  = (r_state != S_IDLE);
  assign dump_done = r_dump_done;
  assign clr_done  = r_clr_done;

endmodule

// File: tb/tb_rf_access_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for rf_access_ctrl. A behavioural 32x32 register file (x0 reads
// zero) sits behind the controller. Table-driven vectors cover IDLE pass-
// through and debug writes; hand-written sequences cover dumps (free-running
// and back-pressured), clear with competing requests, and reset mid-dump.
// ---------------------------------------------------------------------------
module tb_rf_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_we;
  logic [4:0]  cpu_wr;
  logic [31:0] cpu_wd;
  logic [4:0]  cpu_rr2;
  logic        cpu_halt;
  logic        rf_we;
  logic [4:0]  rf_wr;
  logic [31:0] rf_wd;
  logic [4:0]  rf_rr2;
  logic [31:0] rf_rd2;
  logic        dbg_wr_req;
  logic [4:0]  dbg_wr_addr;
  logic [31:0] dbg_wr_data;
  logic        dbg_wr_ack;
  logic        dump_start;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;
  logic        dump_done;
  logic        clr_start;
  logic        clr_done;

  int checks   = 0;
  int failures = 0;

`ifdef RFCTL_DUMP_SKIP_X0_EN
  localparam int START = 1;
`else
  localparam int START = 0;
`endif

  rf_access_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_we     (cpu_we),
    .cpu_wr     (cpu_wr),
    .cpu_wd     (cpu_wd),
    .cpu_rr2    (cpu_rr2),
    .cpu_halt   (cpu_halt),
    .rf_we      (rf_we),
    .rf_wr      (rf_wr),
    .rf_wd      (rf_wd),
    .rf_rr2     (rf_rr2),
    .rf_rd2     (rf_rd2),
    .dbg_wr_req (dbg_wr_req),
    .dbg_wr_addr(dbg_wr_addr),
    .dbg_wr_data(dbg_wr_data),
    .dbg_wr_ack (dbg_wr_ack),
    .dump_start (dump_start),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data),
    .dump_done  (dump_done),
    .clr_start  (clr_start),
    .clr_done   (clr_done)
  );

  always #5 clk = ~clk;

  // Behavioural register file: x0 is never written.
  logic [31:0] rf_mem [32] = '{default: 32'd0};
  always @(posedge clk) begin
    if (rf_we && rf_wr != 5'd0) rf_mem[rf_wr] <= rf_wd;
  end
  assign rf_rd2 = rf_mem[rf_rr2];

  typedef struct {
    logic        cpu_we;
    logic [4:0]  cpu_wr;
    logic [31:0] cpu_wd;
    logic [4:0]  cpu_rr2;
    logic        wreq;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        e_halt;
    logic        e_we;
    logic [4:0]  e_wr;
    logic [31:0] e_wd;
    logic        e_ack;
    logic [31:0] e_rd2;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    int cyc;
    logic [3:0] pat;

    // cpu_we cpu_wr cpu_wd rr2 | req addr data | halt we wr wd ack rd2
    vecs[0]  = '{1'b1, 5'd3, 32'h33, 5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 5'd3,  32'h33,       1'b0, 32'h0};
    vecs[1]  = '{1'b1, 5'd7, 32'h77, 5'd3,  1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 1'b1, 5'd7,  32'h77,       1'b0, 32'h33};
    vecs[2]  = '{1'b1, 5'd9, 32'h99, 5'd3,  1'b0, 5'd5,  32'hDEADBEEF, 1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 32'h33};
    vecs[3]  = '{1'b0, 5'd0, 32'h0,  5'd5,  1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 32'hDEADBEEF};
    vecs[4]  = '{1'b0, 5'd0, 32'h0,  5'd7,  1'b1, 5'd0,  32'h1234,     1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 32'h77};
    vecs[5]  = '{1'b0, 5'd0, 32'h0,  5'd9,  1'b0, 5'd0,  32'h1234,     1'b1, 1'b0, 5'd0,  32'h1234,     1'b1, 32'h0};
    vecs[6]  = '{1'b0, 5'd0, 32'h0,  5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0};
    vecs[7]  = '{1'b0, 5'd0, 32'h0,  5'd0,  1'b1, 5'd10, 32'hA5A5,     1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0};
    vecs[8]  = '{1'b0, 5'd0, 32'h0,  5'd0,  1'b1, 5'd10, 32'hA5A5,     1'b1, 1'b1, 5'd10, 32'hA5A5,     1'b1, 32'h0};
    vecs[9]  = '{1'b0, 5'd0, 32'h0,  5'd0,  1'b1, 5'd10, 32'hA5A5,     1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0};
    vecs[10] = '{1'b0, 5'd0, 32'h0,  5'd10, 1'b0, 5'd10, 32'hA5A5,     1'b1, 1'b1, 5'd10, 32'hA5A5,     1'b1, 32'hA5A5};
    vecs[11] = '{1'b0, 5'd0, 32'h0,  5'd10, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 32'hA5A5};

    rst_n = 1'b0; cpu_we = 1'b0; cpu_wr = 5'd0; cpu_wd = 32'd0; cpu_rr2 = 5'd0;
    dbg_wr_req = 1'b0; dbg_wr_addr = 5'd0; dbg_wr_data = 32'd0;
    dump_start = 1'b0; dump_ready = 1'b0; clr_start = 1'b0;
    #1;
    repeat (2) step();
    chk("rst_halt", 32'(cpu_halt), 32'd0);
    chk("rst_valid", 32'(dump_valid), 32'd0);
    chk("rst_ack", 32'(dbg_wr_ack), 32'd0);
    chk("rst_dump_done", 32'(dump_done), 32'd0);
    chk("rst_clr_done", 32'(clr_done), 32'd0);
    chk("rst_dump_idx", 32'(dump_idx), 32'd0);
    rst_n = 1'b1;

    // Table: pass-through, debug writes (incl. x0), level re-sample.
    for (int i = 0; i < 12; i++) begin
      cpu_we = vecs[i].cpu_we; cpu_wr = vecs[i].cpu_wr; cpu_wd = vecs[i].cpu_wd;
      cpu_rr2 = vecs[i].cpu_rr2;
      dbg_wr_req = vecs[i].wreq; dbg_wr_addr = vecs[i].waddr; dbg_wr_data = vecs[i].wdata;
      #1;
      chk($sformatf("v%0d_halt", i), 32'(cpu_halt), 32'(vecs[i].e_halt));
      chk($sformatf("v%0d_we", i), 32'(rf_we), 32'(vecs[i].e_we));
      if (vecs[i].e_we) begin
        chk($sformatf("v%0d_wr", i), 32'(rf_wr), 32'(vecs[i].e_wr));
        chk($sformatf("v%0d_wd", i), rf_wd, vecs[i].e_wd);
      end
      chk($sformatf("v%0d_ack", i), 32'(dbg_wr_ack), 32'(vecs[i].e_ack));
      chk($sformatf("v%0d_rd2", i), rf_rd2, vecs[i].e_rd2);
      step();
    end
    dbg_wr_req = 1'b0;

    // Preload x1..x31 = 3*index through the core port.
    for (int r = 1; r < 32; r++) begin
      cpu_we = 1'b1; cpu_wr = 5'(r); cpu_wd = 32'(3 * r);
      step();
    end
    cpu_we = 1'b0;

    // Dump with ready tied high.
    dump_ready = 1'b1; dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    for (k = START; k < 32; k++) begin
      chk($sformatf("dump_valid_%0d", k), 32'(dump_valid), 32'd1);
      chk($sformatf("dump_idx_%0d", k), 32'(dump_idx), 32'(k));
      chk($sformatf("dump_data_%0d", k), dump_data, 32'(3 * k));
      chk($sformatf("dump_we_%0d", k), 32'(rf_we), 32'd0);
      chk($sformatf("dump_done_early_%0d", k), 32'(dump_done), 32'd0);
      step();
    end
    chk("dump_done_pulse", 32'(dump_done), 32'd1);
    chk("dump_halt_after", 32'(cpu_halt), 32'd0);
    chk("dump_valid_after", 32'(dump_valid), 32'd0);
    step();
    chk("dump_done_one_cycle", 32'(dump_done), 32'd0);

    // Dump with ready toggling 1,0,0,1.
    pat = 4'b1001;
    dump_ready = 1'b0; dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    k = START; cyc = 0;
    while (k < 32 && cyc < 200) begin
      dump_ready = pat[cyc % 4];
      #1;
      chk($sformatf("bp_idx_c%0d", cyc), 32'(dump_idx), 32'(k));
      chk($sformatf("bp_data_c%0d", cyc), dump_data, 32'(3 * k));
      chk($sformatf("bp_valid_c%0d", cyc), 32'(dump_valid), 32'd1);
      step();
      if (dump_ready) k++;
      cyc++;
    end
    chk("bp_within_budget", 32'(cyc < 200), 32'd1);
    dump_ready = 1'b0;
    chk("bp_done_pulse", 32'(dump_done), 32'd1);

    // Clear and dump requested together: clear wins.
    clr_start = 1'b1; dump_start = 1'b1;
    step();
    clr_start = 1'b0; dump_start = 1'b0;
    for (int r = 1; r < 32; r++) begin
      chk($sformatf("clr_we_%0d", r), 32'(rf_we), 32'd1);
      chk($sformatf("clr_wr_%0d", r), 32'(rf_wr), 32'(r));
      chk($sformatf("clr_wd_%0d", r), rf_wd, 32'd0);
      chk($sformatf("clr_halt_%0d", r), 32'(cpu_halt), 32'd1);
      chk($sformatf("clr_novalid_%0d", r), 32'(dump_valid), 32'd0);
      step();
    end
    chk("clr_done_pulse", 32'(clr_done), 32'd1);
    chk("clr_halt_after", 32'(cpu_halt), 32'd0);
    chk("clr_no_dump", 32'(dump_valid), 32'd0);
    for (int r = 0; r < 32; r++) begin
      cpu_rr2 = 5'(r);
      #1;
      chk($sformatf("clr_read_x%0d", r), rf_rd2, 32'd0);
    end
    step();

    // Reset at beat 10 of a dump.
    dump_ready = 1'b1; dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    repeat (10) step();
    chk("rst_mid_idx", 32'(dump_idx), 32'(START + 10));
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; dump_ready = 1'b0;
    chk("rst_mid_valid", 32'(dump_valid), 32'd0);
    chk("rst_mid_halt", 32'(cpu_halt), 32'd0);
    chk("rst_mid_done", 32'(dump_done), 32'd0);
    cpu_we = 1'b1; cpu_wr = 5'd4; cpu_wd = 32'hABCD;
    #1;
    chk("rst_mid_pass_we", 32'(rf_we), 32'd1);
    chk("rst_mid_pass_wr", 32'(rf_wr), 32'd4);
    step();
    cpu_we = 1'b0; cpu_rr2 = 5'd4;
    #1;
    chk("rst_mid_no_done", 32'(dump_done), 32'd0);
    chk("rst_mid_read_x4", rf_rd2, 32'hABCD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_access_ctrl.md
Name: rf_access_ctrl

Overview:
- Controller in front of the 32x32 register file. Arbitrates the RF write port and the second read port between the CPU core and an on-board debug path.
- Sequences three debug operations: single debug write, full register dump over a valid/ready stream, and hardware clear of x1..x31.
- Stalls the core via cpu_halt while any debug operation owns the RF.

Parameters:
- NREG, 32, number of architectural registers. Fixed at 32 for this design.
- AW, 5, register index width (log2 NREG).
- DW, 32, data width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
- cpu_we  in  1  core writeback enable.
- cpu_wr  in  AW  core writeback register index.
- cpu_wd  in  DW  core writeback data.
- cpu_rr2  in  AW  core read-port-2 index.
- cpu_halt  out  1  core stall; high while the controller owns the RF.
- rf_we  out  1  to RF write enable.
- rf_wr  out  AW  to RF write index.
- rf_wd  out  DW  to RF write data.
- rf_rr2  out  AW  to RF read-port-2 index.
- rf_rd2  in  DW  from RF read-port-2 data; combinational, same cycle.
- dbg_wr_req  in  1  debug single-write request, level.
- dbg_wr_addr  in  AW  debug write index.
- dbg_wr_data  in  DW  debug write data.
- dbg_wr_ack  out  1  one-cycle pulse when the debug write is performed.
- dump_start  in  1  request a full register dump.
- dump_valid  out  1  dump beat valid.
- dump_ready  in  1  consumer accepts beat.
- dump_idx  out  AW  register index of the current beat.
- dump_data  out  DW  register value of the current beat.
- dump_done  out  1  one-cycle pulse after the last beat is accepted.
- clr_start  in  1  request a clear of x1..x31.
- clr_done  out  1  one-cycle pulse after the last clear write.

Behaviour:
- State register: IDLE, DBGW, DUMP, CLEAR. Index counter idx[AW-1:0].
- Reset (rst_n low at a clock edge): state=IDLE, idx=0. All pulses and dump_valid are low, cpu_halt=0. Reset mid-operation aborts the operation immediately; no done pulse is generated.
- cpu_halt = (state != IDLE). It is decoded from registered state only.
- IDLE:
  - rf_we/rf_wr/rf_wd/rf_rr2 pass through from the cpu_* inputs.
  - Requests are sampled only in IDLE. Priority when several are high in the same cycle: clr_start > dump_start > dbg_wr_req.
  - clr_start -> CLEAR with idx=1. dump_start -> DUMP with idx=0. dbg_wr_req -> DBGW.
  - The core write in the transition cycle still completes.
- DBGW (exactly 1 cycle):
  - rf_we = (dbg_wr_addr != 0); rf_wr = dbg_wr_addr; rf_wd = dbg_wr_data.
  - dbg_wr_ack = 1. A write to x0 is acked but suppressed.
  - Next state: IDLE.
- DUMP:
  - rf_we = 0; rf_rr2 = idx; dump_valid = 1; dump_idx = idx; dump_data = rf_rd2.
  - idx and dump_data hold while valid && !ready.
  - On valid && ready: if idx == NREG-1, then go to IDLE and pulse dump_done in the following cycle (registered); otherwise idx <= idx+1.
  - Back-pressure may last indefinitely; there is no timeout.
- CLEAR:
  - rf_we = 1; rf_wr = idx; rf_wd = 0. One write per cycle.
  - At idx == NREG-1, go to IDLE and pulse clr_done in the next cycle.
  - Exactly 31 write cycles; x0 is never addressed.
- Requests that arrive while not IDLE are ignored, not queued. A level still high on return to IDLE is re-sampled there.
- Outside DUMP: dump_valid=0, dump_idx=0, dump_data=0. dbg_wr_ack is high only in DBGW.
- The counter never wraps: the terminal checks above occur before increment.

Optional Feature:
- Macro RFCTL_DUMP_SKIP_X0_EN.
  - Defined: DUMP starts at idx=1 and produces 31 beats (x1..x31).
  - Undefined: 32 beats, x0..x31. The x0 beat carries whatever the RF returns, expected 0.

Test Plan:
- Reset, then dbg_wr_req with addr=5, data=0xDEADBEEF -> rf_we=1, rf_wr=5 for one cycle; dbg_wr_ack pulses; cpu_halt high for exactly 1 cycle; subsequent read of x5 = 0xDEADBEEF.
- dbg_wr_req addr=0, data=0x1234 -> dbg_wr_ack pulses, rf_we stays 0, x0 reads 0.
- Preload x1..x31 = index*3, dump_start with dump_ready tied 1 -> 32 beats (31 with RFCTL_DUMP_SKIP_X0_EN), with dump_idx/dump_data = k/3k; dump_done pulses one cycle after the final beat; cpu_halt is then low.
- Dump with dump_ready toggling 1,0,0,1 -> no beat lost or duplicated; dump_data is stable while ready is low.
- clr_start and dump_start asserted in the same cycle -> CLEAR wins; 31 cycles of rf_we with rf_wd=0 over idx 1..31; clr_done pulses; all registers read 0 afterwards.
- rst_n driven low at beat 10 of a dump -> next cycle state=IDLE, dump_valid=0, cpu_halt=0, no dump_done; cpu_we writes pass through again.
